// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: WIDTH-bit adder that processes one CHUNK-bit slice per
// clock, least-significant slice first. It takes N = WIDTH/CHUNK ADD cycles
// per operation, followed by a single DONE cycle.
// Optional build macro MCA_SUBTRACT_EN adds a 'sub' input that selects
// X + ~Y + 1 in place of X + Y + cin.
// Reset is synchronous and active-low (rst_n).
module multi_cycle_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             cin,
`ifdef MCA_SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             overflow
);

   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   // Reject configurations the slice datapath cannot represent.
   if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("multi_cycle_adder: WIDTH must be a positive multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] y_reg;
   logic             carry_reg;
   logic [WIDTH-1:0] s_reg;
   logic             cout_reg;
   logic             ovf_reg;
   logic             busy_reg;
   logic             done_reg;

   // Operand B and carry-in as they should be latched on an accepted start.
   // Subtraction is folded in as inverted B with a forced carry-in of one.
   logic [WIDTH-1:0] y_load;
   logic             carry_load;

`ifdef MCA_SUBTRACT_EN
   // Select add or subtract operands for latching.
   always_comb begin
      y_load     = sub ? ~Y : Y;
      carry_load = sub ? 1'b1 : cin;
   end
`else
   // Add-only build: operands pass straight through.
   always_comb begin
      y_load     = Y;
      carry_load = cin;
   end
`endif

   // Slice adder working on the low CHUNK bits of the shifting operand registers.
   logic [CHUNK-1:0] slice_sum;
   logic             slice_cout;
   logic             slice_msb_cin;

   assign {slice_cout, slice_sum} = {1'b0, x_reg[CHUNK-1:0]}
                                  + {1'b0, y_reg[CHUNK-1:0]}
                                  + {{CHUNK{1'b0}}, carry_reg};

   // The carry into the top bit is recovered from that bit's sum and inputs.
   assign slice_msb_cin = x_reg[CHUNK-1] ^ y_reg[CHUNK-1] ^ slice_sum[CHUNK-1];

   // Operands shift right by one slice per ADD cycle, so the active slice
   // always sits at bit 0. The sum fills in from the top, so after N
   // slices every slice is in its final position.
   logic [WIDTH-1:0] x_next;
   logic [WIDTH-1:0] y_next;
   logic [WIDTH-1:0] s_next;

   if (N == 1) begin : g_single
      assign x_next = x_reg;
      assign y_next = y_reg;
      assign s_next = slice_sum;
   end else begin : g_multi
      assign x_next = {{CHUNK{1'b0}}, x_reg[WIDTH-1:CHUNK]};
      assign y_next = {{CHUNK{1'b0}}, y_reg[WIDTH-1:CHUNK]};
      assign s_next = {slice_sum, s_reg[WIDTH-1:CHUNK]};
   end

   // Control FSM and datapath registers. All outputs are registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         carry_reg <= 1'b0;
         s_reg     <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  x_reg     <= X;
                  y_reg     <= y_load;
                  carry_reg <= carry_load;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= ADD;
               end else begin
                  state_reg <= IDLE;
               end
            end
            ADD: begin
               x_reg     <= x_next;
               y_reg     <= y_next;
               carry_reg <= slice_cout;
               s_reg     <= s_next;
               if (cnt_reg == CNT_LAST) begin
                  cout_reg  <= slice_cout;
                  ovf_reg   <= slice_cout ^ slice_msb_cin;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign S        = s_reg;
   assign cout     = cout_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb_multi_cycle_adder: scoreboard bench for multi_cycle_adder (WIDTH=64,
// CHUNK=16). Expected results are pushed when an operation is started and
// checked when done pulses. Define MCA_SUBTRACT_EN to cover subtraction.
module tb_multi_cycle_adder;

   localparam int WIDTH = 64;
   localparam int CHUNK = 16;
   localparam int N     = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] X = '0;
   logic [WIDTH-1:0] Y = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             cout;
   logic             overflow;

   multi_cycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .X        (X),
      .Y        (Y),
      .cin      (cin),
`ifdef MCA_SUBTRACT_EN
      .sub      (sub),
`endif
      .busy     (busy),
      .done     (done),
      .S        (S),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             v;
      int               acc;
   } exp_t;

   exp_t             q[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   int               cyc      = 0;
   int               busy_run = 0;
   int               n_done   = 0;
   logic [WIDTH-1:0] last_s   = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // Monitor: on each done pulse, pop the oldest expectation and compare.
   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("S", S, e.s);
            check("cout", {63'd0, cout}, {63'd0, e.c});
            check("overflow", {63'd0, overflow}, {63'd0, e.v});
            check("latency", 64'(cyc - e.acc), 64'(N));
            check("busy_cycles", 64'(busy_run), 64'(N));
            check("busy_in_done", {63'd0, busy}, 64'd0);
            $display("done @%0d: S=0x%016h cout=%0b ovf=%0b", cyc, S, cout, overflow);
         end
         busy_run = 0;
         last_s   = S;
         n_done++;
      end else if (busy) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   // Start an operation; the caller must be at a falling edge. Returns at the
   // falling edge after the accepting rising edge.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sb, input bit push);
      exp_t             e;
      logic [WIDTH-1:0] bb;
      logic             cc;
      logic [WIDTH:0]   full;
      X     = a;
      Y     = b;
      cin   = ci;
      sub   = sb;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      bb    = sb ? ~b : b;
      cc    = sb ? 1'b1 : ci;
      full  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
      e.s   = full[WIDTH-1:0];
      e.c   = full[WIDTH];
      e.v   = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      e.acc = cyc;
      if (push) q.push_back(e);
      // Scramble operands mid-operation; the result must not change.
      X = ~a;
      Y = ~b;
   endtask

   // Wait until every expected result has been observed, with a bound.
   task automatic drain();
      int t;
      t = 0;
      while ((q.size() != 0 || busy || done) && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) check("drain_timeout", 64'd1, 64'd0);
      @(negedge clk);
   endtask

   // Wait for a done pulse, with a bound; returns at that falling edge.
   task automatic wait_done();
      int t;
      t = 0;
      @(negedge clk);
      while (!done && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) check("done_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      int d0;
      // Reset with start held high; the start must be ignored.
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_S", S, 64'd0);
      check("rst_cout", {63'd0, cout}, 64'd0);
      check("rst_ovf", {63'd0, overflow}, 64'd0);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", {63'd0, busy}, 64'd0);

      // Basic add.
      issue(64'd13800121, 64'd13800223, 1'b0, 1'b0, 1'b1);
      drain();
      check("basic_S", last_s, 64'd27600344);

      // Full carry chain.
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b1);
      drain();
      check("chain_S", last_s, 64'd0);

      // Signed overflow.
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
      drain();
      check("ovf_S", last_s, 64'h8000_0000_0000_0000);

      // Start while busy must be ignored.
      d0 = n_done;
      issue(64'd23, 64'd21, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      X     = 64'd400;
      Y     = 64'd22;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (N + 2) @(negedge clk);
      check("busy_prot_dones", 64'(n_done - d0), 64'd1);
      check("busy_prot_S", last_s, 64'd44);
      check("hold_S", S, 64'd44);

      // Reset in the second ADD cycle aborts the operation.
      issue(64'd4, 64'd3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_S", S, 64'd0);
      repeat (N + 2) @(negedge clk);
      issue(64'd57, 64'd75, 1'b0, 1'b0, 1'b1);
      drain();
      check("after_abort_S", last_s, 64'd132);

      // Back-to-back: next start accepted in the DONE cycle.
      issue(64'd1000, 64'd2345, 1'b1, 1'b0, 1'b1);
      wait_done();
      issue(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0000_FFFF_0001, 1'b0, 1'b0, 1'b1);
      drain();

      // Random operands.
      for (int i = 0; i < 6; i++) begin
         issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)),
               1'b0, 1'b1);
         drain();
      end

`ifdef MCA_SUBTRACT_EN
      issue(64'd400, 64'd22, 1'b0, 1'b1, 1'b1);
      drain();
      check("sub1_S", last_s, 64'd378);
      issue(64'd3, 64'd4, 1'b1, 1'b1, 1'b1);
      drain();
      check("sub2_S", last_s, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 1'b1);
      drain();
`endif

      check("queue_empty", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_cycle_adder.md
MULTI_CYCLE_ADDER -- requirements
Module: multi_cycle_adder

Interface
REQ-001 Parameter WIDTH, default 64, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 16, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to begin an addition; sampled only in IDLE or DONE.
REQ-006 X  input  WIDTH  operand A; sampled on accepted start.
REQ-007 Y  input  WIDTH  operand B; sampled on accepted start.
REQ-008 cin  input  1  carry-in; sampled on accepted start.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 S  output  WIDTH  sum; held stable from done until the next accepted start.
REQ-012 cout  output  1  unsigned carry-out of bit WIDTH-1.
REQ-013 overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-014 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-015 A start SHALL be accepted when the state is IDLE or DONE. Acceptance latches X, Y and cin, clears the chunk counter, and moves the FSM to ADD.
REQ-016 In ADD, each cycle SHALL add one CHUNK-bit slice, least-significant first, using the carry registered from the previous slice. The result slice is written into S.
REQ-017 After exactly N = WIDTH/CHUNK ADD cycles, the FSM SHALL go to DONE. done SHALL be high for the single cycle in which the state is DONE.
REQ-018 Latency: start is accepted at edge k. done SHALL be high in the cycle following edge k+N.
REQ-019 DONE SHALL return to IDLE on the next edge, unless start is high. In that case a new operation begins (back-to-back throughput of one result per N+1 cycles).
REQ-020 start SHALL be ignored while busy. Operand changes during ADD SHALL NOT affect the result.
REQ-021 busy SHALL be 1 exactly in ADD.
REQ-022 S SHALL equal (X + Y + cin) mod 2^WIDTH, and cout SHALL equal the carry out of the full sum.
REQ-023 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB of the final slice.
REQ-024 S, cout and overflow SHALL hold their values until the next accepted start. Their contents during ADD are don't-care.
REQ-025 N = 1 (CHUNK = WIDTH) SHALL be supported, giving a one-cycle ADD.

Reset
REQ-026 When rst_n = 0 at a rising edge, the FSM SHALL enter IDLE and the outputs SHALL take these values: busy = 0, done = 0, S = 0, cout = 0, overflow = 0, and the chunk counter = 0.
REQ-027 Reset asserted during ADD SHALL abort the operation. done SHALL NOT be produced for it.
REQ-028 start coincident with rst_n = 0 SHALL be ignored.

Configuration
REQ-029 Macro MCA_SUBTRACT_EN.
- When defined, an extra input port sub (1 bit) is present and is sampled on an accepted start.
- With sub = 1, the result SHALL be X + ~Y + 1, and cin is ignored. cout = 1 means no borrow. overflow is the signed subtraction overflow.
- With sub = 0, the behaviour SHALL be that of REQ-022.
- When the macro is not defined, the sub port SHALL NOT exist and the block is add-only.

Verification (WIDTH=64, CHUNK=16, N=4)
REQ-030 Basic add: X=13800121, Y=13800223, cin=0, one-cycle start.
-> busy for 4 cycles, then done pulses once with S=27600344, cout=0, overflow=0.
REQ-031 Carry chain: X=0xFFFF_FFFF_FFFF_FFFF, Y=0, cin=1.
-> S=0, cout=1, overflow=0.
REQ-032 Signed overflow: X=0x7FFF_FFFF_FFFF_FFFF, Y=1, cin=0.
-> S=0x8000_0000_0000_0000, cout=0, overflow=1.
REQ-033 Busy protection: start X=23, Y=21, then pulse start with X=400, Y=22 two cycles later.
-> S=44 only, a single done pulse.
REQ-034 Reset mid-op: start X=4, Y=3, then rst_n=0 for one edge in the 2nd ADD cycle.
-> IDLE, no done, S=0.
-> A later start with X=57, Y=75 gives S=132 after 4 cycles.
REQ-035 With MCA_SUBTRACT_EN defined:
- sub=1, X=400, Y=22 -> S=378, cout=1.
- sub=1, X=3, Y=4 -> S=0xFFFF_FFFF_FFFF_FFFF, cout=0, overflow=0.
